traffic_checker: RTL

Receive-side consumer for the FX2 slave-FIFO traffic path. It takes the 16-bit words the FIFO interface reads from the host (the host sends an incrementing counter pattern) and checks them for sequence continuity. It acquires lock on the pattern, counts words and sequence errors, and reports the last bad word. It sits directly downstream of the slave-FIFO read port in the IFCLK domain, and its status outputs feed the register/LED readout.

---
 rtl/traffic_checker_if.sv | 11 +
 rtl/traffic_checker.sv | 130 +++++++++++++
 2 files changed

// File: rtl/traffic_checker_if.sv
// Slave-FIFO read beat: word, valid and the checker's ready.
interface traffic_checker_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;

  modport master (output IN_DATA, output IN_VALID, input IN_READY);
  modport slave  (input IN_DATA, input IN_VALID, output IN_READY);
endinterface

// File: rtl/traffic_checker.sv
// Checks an incrementing host counter stream for continuity: lock, error count, last bad word.
// All outputs registered, one cycle after the accepting edge; never back-pressures outside reset.
module traffic_checker #(
  parameter int DATA_W     = 16,
  parameter int ERR_W      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic                IFCLK,
  input  logic                RESET,
  input  logic                CLEAR,
  traffic_checker_if.slave    fifo_if,
  output logic                LOCKED,
  output logic                ERR_PULSE,
  output logic [ERR_W-1:0]    ERR_COUNT,
  output logic [31:0]         WORD_COUNT,
  output logic [DATA_W-1:0]   LAST_BAD
);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic [3:0]        run_q, run_d;
  logic              ready_q;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] last_bad_q, last_bad_d;

  logic              beat;
  logic              match;
  logic [DATA_W-1:0] data_inc;
  logic [3:0]        run_inc;

  assign beat     = fifo_if.IN_VALID & ready_q;
  assign match    = (fifo_if.IN_DATA == expected_q);
  assign data_inc = fifo_if.IN_DATA + DATA_W'(1);
  assign run_inc  = run_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    last_bad_d  = last_bad_q;

    if (beat) begin
      word_cnt_d = word_cnt_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          expected_d = data_inc;
          run_d      = 4'd1;
          state_d    = S_SEEK;
        end
        S_SEEK: begin
          expected_d = data_inc;
          if (match) begin
            run_d = run_inc;
            if (run_inc == LOCK_N) begin
              state_d = S_LOCKED;
              run_d   = 4'd0;
            end
          end else begin
            run_d = 4'd1;
          end
        end
        S_LOCKED: begin
          if (match) begin
            expected_d = expected_q + DATA_W'(1);
            run_d      = 4'd0;
          end else begin
            // Resync to the received word so a single slip costs one error, not a burst.
            expected_d  = data_inc;
            err_pulse_d = 1'b1;
            last_bad_d  = fifo_if.IN_DATA;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            run_d = run_inc;
            if (run_inc == LOCK_N) begin
              state_d = S_SEEK;
              run_d   = 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (CLEAR) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
      last_bad_d = '0;
    end
  end

  always_ff @(posedge IFCLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      expected_q  <= '0;
      run_q       <= '0;
      ready_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      last_bad_q  <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      run_q       <= run_d;
      ready_q     <= 1'b1;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      last_bad_q  <= last_bad_d;
    end
  end

  assign fifo_if.IN_READY = ready_q;
  assign LOCKED           = (state_q == S_LOCKED);
  assign ERR_PULSE        = err_pulse_q;
  assign ERR_COUNT        = err_cnt_q;
  assign WORD_COUNT       = word_cnt_q;
  assign LAST_BAD         = last_bad_q;

endmodule
